// File: rtl/multicore_ram_arbiter.sv
// Round-robin or fixed-priority arbiter sharing one dual-port RAM among N_CORES cores; write ack at t+1, read ack at t+2+RD_LATENCY.
// Requests are level-held until acked. A core with a read anywhere in the return pipeline is not re-granted until its ack cycle has passed.
module multicore_ram_arbiter #(
    parameter int N_CORES    = 4,
    parameter int DATA_W     = 1,
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_CORES-1:0]          CORE_WE,
    input  logic [N_CORES-1:0]          CORE_RR,
    input  logic [N_CORES*ADDR_W-1:0]   CORE_ADDR,
    input  logic [N_CORES*DATA_W-1:0]   CORE_WDATA,
    output logic [N_CORES*DATA_W-1:0]   CORE_RDATA,
    output logic [N_CORES-1:0]          CORE_WR_ACK,
    output logic [N_CORES-1:0]          CORE_RD_ACK,
    output logic                        RAM_WE,
    output logic [ADDR_W-1:0]           RAM_WADDR,
    output logic [DATA_W-1:0]           RAM_WDATA,
    output logic                        RAM_RE,
    output logic [ADDR_W-1:0]           RAM_RADDR,
    input  logic [DATA_W-1:0]           RAM_RDATA
);

    localparam int IDX_W = $clog2(N_CORES);
    localparam int DEPTH = RD_LATENCY + 1;

    // First pass honours the round-robin pointer; second pass wraps around.
    function automatic logic [IDX_W:0] pick(input logic [N_CORES-1:0] elig,
                                            input logic [IDX_W-1:0]   ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int c = 0; c < N_CORES; c++) begin
            if (!found && elig[c] && (FIXED_PRIO != 0 || IDX_W'(c) >= ptr)) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
        for (int c = 0; c < N_CORES; c++) begin
            if (!found && elig[c]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_CORES - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [IDX_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [N_CORES-1:0]        wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
    logic                      ram_we_q, ram_we_d, ram_re_q, ram_re_d;
    logic [ADDR_W-1:0]         waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [N_CORES*DATA_W-1:0] rdata_q, rdata_d;
    logic [DEPTH-1:0]          rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]          rd_idx_q [DEPTH];
    logic [IDX_W-1:0]          rd_idx_d [DEPTH];

    logic [N_CORES-1:0] wr_elig, rd_elig, rd_busy;
    logic               wr_gnt_vld, rd_gnt_vld;
    logic [IDX_W-1:0]   wr_gnt_idx, rd_gnt_idx;

    always_comb begin
        wr_elig = CORE_WE & ~wr_ack_q;
        rd_busy = rd_ack_q;
        for (int s = 0; s < DEPTH; s++) begin
            if (rd_vld_q[s]) rd_busy[rd_idx_q[s]] = 1'b1;
        end
        rd_elig = CORE_RR & ~rd_busy;
        {wr_gnt_vld, wr_gnt_idx} = pick(wr_elig, wr_ptr_q);
        {rd_gnt_vld, rd_gnt_idx} = pick(rd_elig, rd_ptr_q);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_ack_d = '0;
        ram_we_d = wr_gnt_vld;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (wr_gnt_vld) begin
            wr_ack_d[wr_gnt_idx] = 1'b1;
            waddr_d  = CORE_ADDR[int'(wr_gnt_idx)*ADDR_W +: ADDR_W];
            wdata_d  = CORE_WDATA[int'(wr_gnt_idx)*DATA_W +: DATA_W];
            wr_ptr_d = next_ptr(wr_gnt_idx);
        end

        rd_ptr_d = rd_ptr_q;
        ram_re_d = rd_gnt_vld;
        raddr_d  = raddr_q;
        if (rd_gnt_vld) begin
            raddr_d  = CORE_ADDR[int'(rd_gnt_idx)*ADDR_W +: ADDR_W];
            rd_ptr_d = next_ptr(rd_gnt_idx);
        end

        // Stage s carries a grant made s+1 cycles ago; the last stage meets RAM_RDATA.
        rd_vld_d    = {rd_vld_q[DEPTH-2:0], rd_gnt_vld};
        rd_idx_d[0] = rd_gnt_idx;
        for (int s = 1; s < DEPTH; s++) rd_idx_d[s] = rd_idx_q[s-1];

        rd_ack_d = '0;
        rdata_d  = rdata_q;
        if (rd_vld_q[DEPTH-1]) begin
            rd_ack_d[rd_idx_q[DEPTH-1]] = 1'b1;
            rdata_d[int'(rd_idx_q[DEPTH-1])*DATA_W +: DATA_W] = RAM_RDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_ack_q <= '0;
            rd_ack_q <= '0;
            ram_we_q <= 1'b0;
            ram_re_q <= 1'b0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_vld_q <= '0;
            for (int s = 0; s < DEPTH; s++) rd_idx_q[s] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ack_q <= wr_ack_d;
            rd_ack_q <= rd_ack_d;
            ram_we_q <= ram_we_d;
            ram_re_q <= ram_re_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_vld_q <= rd_vld_d;
            for (int s = 0; s < DEPTH; s++) rd_idx_q[s] <= rd_idx_d[s];
        end
    end

    assign CORE_RDATA  = rdata_q;
    assign CORE_WR_ACK = wr_ack_q;
    assign CORE_RD_ACK = rd_ack_q;
    assign RAM_WE      = ram_we_q;
    assign RAM_WADDR   = waddr_q;
    assign RAM_WDATA   = wdata_q;
    assign RAM_RE      = ram_re_q;
    assign RAM_RADDR   = raddr_q;

endmodule

// File: tb/tb_multicore_ram_arbiter.sv
// Bench for multicore_ram_arbiter: u_a is round-robin with RD_LATENCY=2, u_b is fixed priority with RD_LATENCY=1, both on shared core inputs.
module tb_multicore_ram_arbiter;

    localparam logic [63:0] ASET0 = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    localparam logic [63:0] ASET1 = {16'h0033, 16'h0005, 16'h0031, 16'h0030};
    localparam logic [31:0] WDAT  = 32'h53525150;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  core_we, core_rr;
    logic [63:0] core_addr;
    logic [31:0] core_wdata;

    logic [31:0] a_rdata, b_rdata;
    logic [3:0]  a_wr_ack, a_rd_ack, b_wr_ack, b_rd_ack;
    logic        a_ram_we, a_ram_re, b_ram_we, b_ram_re;
    logic [15:0] a_waddr, a_raddr, b_waddr, b_raddr;
    logic [7:0]  a_wdata, b_wdata, a_ram_rdata, b_ram_rdata;
    logic [7:0]  a_d1, a_d2, b_d1;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    multicore_ram_arbiter #(.N_CORES(4), .DATA_W(8), .ADDR_W(16), .RD_LATENCY(2), .FIXED_PRIO(0)) u_a (
        .CLK(CLK), .RST(RST), .CORE_WE(core_we), .CORE_RR(core_rr), .CORE_ADDR(core_addr),
        .CORE_WDATA(core_wdata), .CORE_RDATA(a_rdata), .CORE_WR_ACK(a_wr_ack), .CORE_RD_ACK(a_rd_ack),
        .RAM_WE(a_ram_we), .RAM_WADDR(a_waddr), .RAM_WDATA(a_wdata), .RAM_RE(a_ram_re),
        .RAM_RADDR(a_raddr), .RAM_RDATA(a_ram_rdata));

    multicore_ram_arbiter #(.N_CORES(4), .DATA_W(8), .ADDR_W(16), .RD_LATENCY(1), .FIXED_PRIO(1)) u_b (
        .CLK(CLK), .RST(RST), .CORE_WE(core_we), .CORE_RR(core_rr), .CORE_ADDR(core_addr),
        .CORE_WDATA(core_wdata), .CORE_RDATA(b_rdata), .CORE_WR_ACK(b_wr_ack), .CORE_RD_ACK(b_rd_ack),
        .RAM_WE(b_ram_we), .RAM_WADDR(b_waddr), .RAM_WDATA(b_wdata), .RAM_RE(b_ram_re),
        .RAM_RADDR(b_raddr), .RAM_RDATA(b_ram_rdata));

    // RAM contents are a fixed function of address: 0x0005 -> 0xA5, 0x0010+i -> 0xB0+i.
    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0] + 8'hA0;
    endfunction

    always @(posedge CLK) begin
        a_d1 <= rom(a_raddr);
        a_d2 <= a_d1;
        b_d1 <= rom(b_raddr);
    end
    assign a_ram_rdata = a_d2;
    assign b_ram_rdata = b_d1;

    typedef struct {
        logic        rst;
        logic [3:0]  we;
        logic [3:0]  rr;
        logic        aset;
        logic [28:0] a_wr;   // {RAM_WE, RAM_WADDR, RAM_WDATA, CORE_WR_ACK}
        logic [52:0] a_rd;   // {RAM_RE, RAM_RADDR, CORE_RD_ACK, CORE_RDATA}
        logic [35:0] b_rd;   // {CORE_RD_ACK, CORE_RDATA}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] we, input logic [3:0] rr,
                                input logic aset, input logic awe, input logic [15:0] awa,
                                input logic [7:0] awd, input logic [3:0] awk, input logic are,
                                input logic [15:0] ara, input logic [3:0] ark,
                                input logic [31:0] ard, input logic [3:0] brk,
                                input logic [31:0] brd);
        vec_t v;
        v.rst  = rst;
        v.we   = we;
        v.rr   = rr;
        v.aset = aset;
        v.a_wr = {awe, awa, awd, awk};
        v.a_rd = {are, ara, ark, ard};
        v.b_rd = {brk, brd};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] we, input logic [3:0] rr);
        @(posedge CLK);
        #1;
        RST     = rst;
        core_we = we;
        core_rr = rr;
        @(negedge CLK);
    endtask

    logic [28:0] fp_exp [1:9];

    initial begin
        RST        = 1'b1;
        core_we    = '0;
        core_rr    = '0;
        core_addr  = ASET0;
        core_wdata = WDAT;

        //            rst we     rr     as  we wadr   wd     wack    re rada   rack    rdata         back    brdata
        tbl.push_back(mk(1, 4'hF, 4'hF, 0,  0, 16'h0, 8'h0,  4'h0,   0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(1, 4'hF, 4'hF, 0,  0, 16'h0, 8'h0,  4'h0,   0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0,  0, 16'h0, 8'h0,  4'h0,   0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0,  1, 16'h10, 8'h50, 4'h1,  0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0,  1, 16'h11, 8'h51, 4'h2,  0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0,  1, 16'h12, 8'h52, 4'h4,  0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0,  1, 16'h13, 8'h53, 4'h8,  0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0,  1, 16'h10, 8'h50, 4'h1,  0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0,  1, 16'h11, 8'h51, 4'h2,  0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h4, 1,  0, 16'h11, 8'h51, 4'h0,  0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h4, 1,  0, 16'h11, 8'h51, 4'h0,  1, 16'h5, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h4, 1,  0, 16'h11, 8'h51, 4'h0,  0, 16'h5, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'h0, 4'h4, 1,  0, 16'h11, 8'h51, 4'h0,  0, 16'h5, 4'h0,   32'h0,        4'h4,   32'h00A50000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1,  0, 16'h11, 8'h51, 4'h0,  0, 16'h5, 4'h4,   32'h00A50000, 4'h0,   32'h00A50000));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1,  0, 16'h11, 8'h51, 4'h0,  0, 16'h5, 4'h0,   32'h00A50000, 4'h0,   32'h00A50000));
        tbl.push_back(mk(1, 4'h0, 4'h0, 0,  0, 16'h11, 8'h51, 4'h0,  0, 16'h5, 4'h0,   32'h00A50000, 4'h0,   32'h00A50000));
        tbl.push_back(mk(0, 4'h0, 4'hF, 0,  0, 16'h0, 8'h0,  4'h0,   0, 16'h0, 4'h0,   32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'h0, 4'hF, 0,  0, 16'h0, 8'h0,  4'h0,   1, 16'h10, 4'h0,  32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'h0, 4'hF, 0,  0, 16'h0, 8'h0,  4'h0,   1, 16'h11, 4'h0,  32'h0,        4'h0,   32'h0));
        tbl.push_back(mk(0, 4'h0, 4'hF, 0,  0, 16'h0, 8'h0,  4'h0,   1, 16'h12, 4'h0,  32'h0,        4'h1,   32'h000000B0));
        tbl.push_back(mk(0, 4'h0, 4'hE, 0,  0, 16'h0, 8'h0,  4'h0,   1, 16'h13, 4'h1,  32'h000000B0, 4'h2,   32'h0000B1B0));
        tbl.push_back(mk(0, 4'h0, 4'hC, 0,  0, 16'h0, 8'h0,  4'h0,   0, 16'h13, 4'h2,  32'h0000B1B0, 4'h4,   32'h00B2B1B0));
        tbl.push_back(mk(0, 4'h0, 4'h8, 0,  0, 16'h0, 8'h0,  4'h0,   0, 16'h13, 4'h4,  32'h00B2B1B0, 4'h8,   32'hB3B2B1B0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0,  0, 16'h0, 8'h0,  4'h0,   0, 16'h13, 4'h8,  32'hB3B2B1B0, 4'h0,   32'hB3B2B1B0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0,  0, 16'h0, 8'h0,  4'h0,   0, 16'h13, 4'h0,  32'hB3B2B1B0, 4'h0,   32'hB3B2B1B0));

        repeat (3) @(posedge CLK);

        foreach (tbl[k]) begin
            @(posedge CLK);
            #1;
            RST       = tbl[k].rst;
            core_we   = tbl[k].we;
            core_rr   = tbl[k].rr;
            core_addr = tbl[k].aset ? ASET1 : ASET0;
            @(negedge CLK);
            chk($sformatf("row%0d_a_wr", k), {a_ram_we, a_waddr, a_wdata, a_wr_ack}, tbl[k].a_wr);
            chk($sformatf("row%0d_a_rd", k), {a_ram_re, a_raddr, a_rd_ack, a_rdata}, tbl[k].a_rd);
            chk($sformatf("row%0d_b_rd", k), {b_rd_ack, b_rdata}, tbl[k].b_rd);
        end

        // Fixed priority: cores 1 and 3 hold WE, then core 1 drops out.
        core_addr = ASET0;
        fp_exp = '{{1'b0, 16'h0000, 8'h00, 4'h0}, {1'b1, 16'h0011, 8'h51, 4'h2},
                   {1'b1, 16'h0013, 8'h53, 4'h8}, {1'b1, 16'h0011, 8'h51, 4'h2},
                   {1'b1, 16'h0013, 8'h53, 4'h8}, {1'b1, 16'h0011, 8'h51, 4'h2},
                   {1'b1, 16'h0013, 8'h53, 4'h8}, {1'b0, 16'h0013, 8'h53, 4'h0},
                   {1'b1, 16'h0013, 8'h53, 4'h8}};
        step(1'b1, 4'h0, 4'h0);
        for (int s = 1; s <= 9; s++) begin
            step(1'b0, (s <= 5) ? 4'b1010 : 4'b1000, 4'h0);
            chk($sformatf("fixprio_s%0d", s), {b_ram_we, b_waddr, b_wdata, b_wr_ack}, fp_exp[s]);
        end

        // Reset one cycle after a read grant: the read must vanish.
        step(1'b1, 4'h0, 4'h0);
        step(1'b0, 4'h0, 4'b0001);
        step(1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'h0, 4'h0);
            chk($sformatf("rstrd_noack_a%0d", i), a_rd_ack, 4'h0);
            chk($sformatf("rstrd_noack_b%0d", i), b_rd_ack, 4'h0);
        end

        // Fresh read from the same core completes normally.
        step(1'b0, 4'h0, 4'b0001);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 4'h0, 4'b0001);
            if (i == 1) chk("rerd_ram_re", {a_ram_re, a_raddr, b_ram_re, b_raddr},
                            {1'b1, 16'h0010, 1'b1, 16'h0010});
            if (i == 3) chk("rerd_b_ack", {b_rd_ack, b_rdata[7:0], a_rd_ack}, {4'h1, 8'hB0, 4'h0});
            if (i == 4) chk("rerd_a_ack", {a_rd_ack, a_rdata}, {4'h1, 32'h000000B0});
        end
        repeat (4) step(1'b0, 4'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
